// File: rtl/channel_stream_sender.sv
// Valid/ready stream sender: emits base, base+stride, ... for count beats after a start strobe.
// Optional CHANNEL_STREAM_SENDER_CHECKSUM_EN appends one wrapping-sum beat after the data words.
module channel_stream_sender #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [WIDTH-1:0]     stride,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  // state | meaning
  // IDLE  | waiting for start; done may pulse here
  // RUN   | presenting data words, holding each until accepted
  // CHK   | presenting the checksum beat (checksum build only)
  typedef enum logic [1:0] {IDLE, RUN, CHK} state_t;

  state_t               state;
  logic [WIDTH-1:0]     stride_q;
  logic [CNT_WIDTH-1:0] rem;
`ifdef CHANNEL_STREAM_SENDER_CHECKSUM_EN
  logic [WIDTH-1:0]     sum_q;
`endif

  // rem counts the beats still to come after the one currently presented
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stride_q  <= '0;
      rem       <= '0;
`ifdef CHANNEL_STREAM_SENDER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state     <= RUN;
              out_valid <= 1'b1;
              out_data  <= base;
              busy      <= 1'b1;
              stride_q  <= stride;
              rem       <= count - CNT_WIDTH'(1);
`ifdef CHANNEL_STREAM_SENDER_CHECKSUM_EN
              sum_q     <= base;
              out_last  <= 1'b0;
`else
              out_last  <= (count == CNT_WIDTH'(1));
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            if (rem != '0) begin
              out_data <= out_data + stride_q;
              rem      <= rem - CNT_WIDTH'(1);
`ifdef CHANNEL_STREAM_SENDER_CHECKSUM_EN
              // running sum already includes the word being loaded
              sum_q    <= sum_q + out_data + stride_q;
`else
              out_last <= (rem == CNT_WIDTH'(1));
`endif
            end else begin
`ifdef CHANNEL_STREAM_SENDER_CHECKSUM_EN
              state     <= CHK;
              out_data  <= sum_q;
              out_last  <= 1'b1;
`else
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end
        end
        CHK: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
